fb_write_ctrl: RTL and testbench
================================

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 9600, meaning number of 8-bit framebuffer words (320x240 at 1 bpp).
REQ-002 SHALL have parameter ADDR_W, default 14, meaning write address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning idle clocks after which a partial command or frame is abandoned.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port rx_data, input, 8, meaning received serial byte.
REQ-007 SHALL have port rx_valid, input, 1, meaning one-cycle strobe; rx_data is valid in that cycle.
REQ-008 SHALL have port write_address, output, ADDR_W, meaning the RAM write address.
REQ-009 SHALL have port wr_data, output, 8, meaning the RAM write data.
REQ-010 SHALL have port we, output, 1, meaning the RAM write enable.
REQ-011 SHALL have port busy, output, 1, meaning a clear sweep is in progress.
REQ-012 SHALL have port frame_done, output, 1, meaning a one-cycle pulse when the last word (RAM_WORDS-1) is written.
REQ-013 SHALL have port err_overflow, output, 1, meaning sticky flag: a byte was dropped during a clear sweep.
REQ-014 SHALL have port err_addr, output, 1, meaning sticky flag: an out-of-range address was received.

Function
REQ-015 SHALL implement the states IDLE, ADDR_HI, ADDR_LO, DATA and CLEAR.
REQ-016 SHALL register all outputs; a byte accepted at cycle n drives we/write_address/wr_data at cycle n+1, with we high for exactly one cycle per byte.
REQ-017 In IDLE: 0xA5 -> DATA, addr=0; 0x5A -> ADDR_HI; 0xC3 -> CLEAR, addr=0; any other byte is ignored with no write.
REQ-018 ADDR_HI SHALL store rx_data[ADDR_W-9:0] as the high bits and go to ADDR_LO; ADDR_LO SHALL store rx_data as the low bits and go to DATA.
REQ-019 If the assembled address is >= RAM_WORDS, addr SHALL be 0 and err_addr SHALL set.
REQ-020 In DATA, each rx_valid byte SHALL be written at addr, after which addr increments; command codes carry no meaning in DATA.
REQ-021 A write at addr == RAM_WORDS-1 SHALL assert frame_done in the same cycle as that we, reset addr to 0 and return to IDLE; addr never exceeds RAM_WORDS-1.
REQ-022 CLEAR SHALL start the cycle after 0xC3 is accepted and assert we on RAM_WORDS consecutive cycles, with wr_data=0x00 and write_address 0..RAM_WORDS-1 ascending.
REQ-023 busy SHALL be high for exactly the cycles in which CLEAR drives we.
REQ-024 frame_done SHALL pulse with the final clear write, and the state SHALL then return to IDLE.
REQ-025 rx_valid during CLEAR SHALL drop the byte and set err_overflow; the sweep is not disturbed.
REQ-026 A timeout counter SHALL clear on each rx_valid and increment otherwise while in ADDR_HI, ADDR_LO or DATA.
REQ-027 If the timeout counter reaches TIMEOUT_CYCLES-1, the state SHALL go to IDLE with no write, and addr is retained but unused.
REQ-028 The timeout counter SHALL be held at 0 in IDLE and CLEAR.
REQ-029 When rx_valid and a timeout occur in the same cycle, the byte SHALL be processed and the timeout counter cleared.
REQ-030 err_overflow and err_addr SHALL be cleared only by reset.

Reset
REQ-031 On reset assertion, immediately: state IDLE, addr 0, timeout counter 0, write_address 0, wr_data 0x00, we 0, busy 0, frame_done 0, err_overflow 0, err_addr 0.
REQ-032 Reset mid-CLEAR or mid-DATA SHALL abort with no further writes; after release the block waits in IDLE for a command.

Verification
REQ-033 Bench: 0xA5 then 9600 bytes i mod 256 -> 9600 writes, addr 0..9599, data i mod 256; frame_done on the last write only; state IDLE.
REQ-034 Bench: 0x5A,0x25,0x7E then 3 bytes 0x11,0x22,0x33 -> writes at 9598,9599 (frame_done pulses here), then IDLE; 0x33 is ignored and not written.
REQ-035 Bench: 0x5A,0x3F,0xFF -> err_addr=1, addr=0; next byte 0x77 is written at address 0.
REQ-036 Bench: 0xC3 with rx_valid pulsed at sweep cycle 100 -> 9600 contiguous zero writes with busy high; err_overflow=1; frame_done at address 9599.
REQ-037 Bench (TIMEOUT_CYCLES=16): 0xA5, 2 bytes, then 16 idle cycles, then 0x42 -> 0x42 is not written (IDLE ignores it); next 0xA5 restarts at address 0.
REQ-038 Bench: reset asserted mid-CLEAR at address 500 -> we=0 and busy=0 immediately, without waiting for a clock edge; both flags are 0 after release.

Source files
------------

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: turns a serial command byte stream into framebuffer RAM writes (set-address, data burst, clear sweep) with sticky error flags
module fb_write_ctrl #(
  parameter int RAM_WORDS = 9600,
  parameter int ADDR_W = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        wr_data,
  output logic              we,
  output logic              busy,
  output logic              frame_done,
  output logic              err_overflow,
  output logic              err_addr
);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, CLEAR} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RAM_WORDS - 1);
  localparam logic [ADDR_W:0] WORDS = (ADDR_W + 1)'(RAM_WORDS);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, wr_a, wa_n, full;
  logic [ADDR_W-9:0] hi, hi_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [7:0] wr_d, wd_n;
  logic do_wr, clr, bad, we_n, busy_n, fd_n, ovf_n, ea_n;
  always_comb begin
    state_n = state;
    addr_n = addr;
    hi_n = hi;
    tmo_n = '0;
    ovf_n = err_overflow;
    ea_n = err_addr;
    do_wr = 1'b0;
    clr = 1'b0;
    wr_a = addr;
    wr_d = rx_data;
    full = {hi, rx_data};
    bad = {1'b0, full} >= WORDS;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == 8'hA5) begin
          state_n = DATA;
          addr_n = '0;
        end else if (rx_data == 8'h5A) state_n = ADDR_HI;
        else if (rx_data == 8'hC3) begin
          state_n = CLEAR;
          do_wr = 1'b1;
          clr = 1'b1;
          wr_a = '0;
          wr_d = '0;
        end
      end
      ADDR_HI, ADDR_LO, DATA: begin
        tmo_n = rx_valid ? '0 : tmo + 1'b1;
        if (rx_valid) begin
          if (state == ADDR_HI) begin
            hi_n = rx_data[ADDR_W-9:0];
            state_n = ADDR_LO;
          end else if (state == ADDR_LO) begin
            state_n = DATA;
            addr_n = bad ? '0 : full;
            ea_n = err_addr | bad;
          end else do_wr = 1'b1;
        end else if (tmo == TMO_MAX) begin
          state_n = IDLE;
          tmo_n = '0;
        end
      end
      CLEAR: begin
        do_wr = 1'b1;
        clr = 1'b1;
        wr_d = '0;
        ovf_n = err_overflow | rx_valid;
      end
      default: state_n = IDLE;
    endcase
    fd_n = do_wr && wr_a == LAST;
    if (do_wr) begin
      addr_n = fd_n ? '0 : wr_a + 1'b1;
      if (fd_n) state_n = IDLE;
    end
    we_n = do_wr;
    busy_n = clr;
    wa_n = do_wr ? wr_a : write_address;
    wd_n = do_wr ? wr_d : wr_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      hi <= '0;
      tmo <= '0;
      write_address <= '0;
      wr_data <= '0;
      we <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      err_overflow <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      hi <= hi_n;
      tmo <= tmo_n;
      write_address <= wa_n;
      wr_data <= wd_n;
      we <= we_n;
      busy <= busy_n;
      frame_done <= fd_n;
      err_overflow <= ovf_n;
      err_addr <= ea_n;
    end
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: scoreboard bench for fb_write_ctrl (expected writes queued at stimulus, popped on we)
module tb_fb_write_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [13:0] write_address;
  logic [7:0] wr_data;
  logic we, busy, frame_done, err_overflow, err_addr;
  typedef struct packed {
    logic [13:0] a;
    logic [7:0] d;
    logic fd;
    logic b;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cnt;
  fb_write_ctrl #(.RAM_WORDS(9600), .ADDR_W(14), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .write_address(write_address),
    .wr_data(wr_data),
    .we(we),
    .busy(busy),
    .frame_done(frame_done),
    .err_overflow(err_overflow),
    .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic push(input int a, input int d, input logic fd, input logic b);
    q.push_back('{a: 14'(a), d: 8'(d), fd: fd, b: b});
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (we) begin
        if (q.size() == 0) check("unexpected_we", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("addr", 32'(write_address), 32'(e.a));
          check("data", 32'(wr_data), 32'(e.d));
          check("frame_done", 32'(frame_done), 32'(e.fd));
          check("busy", 32'(busy), 32'(e.b));
        end
      end else begin
        check("idle_frame_done", 32'(frame_done), 0);
        check("idle_busy", 32'(busy), 0);
      end
    end
  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    #1;
    check("rst_we", 32'(we), 0);
    check("rst_addr", 32'(write_address), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fd", 32'(frame_done), 0);
    check("rst_ovf", 32'(err_overflow), 0);
    check("rst_eaddr", 32'(err_addr), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    send(8'h11);
    send(8'hA5);
    for (int i = 0; i < 9600; i++) begin
      push(i, i % 256, i == 9599, 1'b0);
      send(8'(i % 256));
    end
    repeat (3) @(posedge clk);
    #1 check("full_frame_q", q.size(), 0);
    send(8'h42);
    send(8'h5A);
    send(8'h25);
    send(8'h7E);
    push(9598, 8'h11, 1'b0, 1'b0);
    push(9599, 8'h22, 1'b1, 1'b0);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    repeat (3) @(posedge clk);
    #1 check("tail_q", q.size(), 0);
    check("eaddr_clean", 32'(err_addr), 0);
    send(8'h5A);
    send(8'h3F);
    send(8'hFF);
    #1 check("eaddr_set", 32'(err_addr), 1);
    push(0, 8'h77, 1'b0, 1'b0);
    send(8'h77);
    repeat (25) @(posedge clk);
    #1 check("bad_addr_q", q.size(), 0);
    for (int i = 0; i < 9600; i++) push(i, 0, i == 9599, 1'b1);
    send(8'hC3);
    cnt = 0;
    for (int i = 0; i < 9600; i++) begin
      @(negedge clk);
      cnt += int'(we && busy);
      rx_data = 8'h55;
      rx_valid = (i == 99);
    end
    rx_valid = 1'b0;
    check("sweep_contig", cnt, 9600);
    repeat (2) @(posedge clk);
    #1 check("clear_q", q.size(), 0);
    check("ovf_set", 32'(err_overflow), 1);
    check("eaddr_sticky", 32'(err_addr), 1);
    send(8'hA5);
    push(0, 1, 1'b0, 1'b0);
    push(1, 2, 1'b0, 1'b0);
    send(8'h01);
    send(8'h02);
    repeat (16) @(posedge clk);
    #1 send(8'h42);
    push(0, 8'h99, 1'b0, 1'b0);
    send(8'hA5);
    send(8'h99);
    repeat (25) @(posedge clk);
    #1 check("timeout_q", q.size(), 0);
    for (int i = 0; i <= 500; i++) push(i, 0, 1'b0, 1'b1);
    send(8'hC3);
    repeat (501) @(negedge clk);
    check("pre_rst_addr", 32'(write_address), 500);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_we", 32'(we), 0);
    check("rst_mid_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mid_q", q.size(), 0);
    check("rst_ovf_clr", 32'(err_overflow), 0);
    check("rst_eaddr_clr", 32'(err_addr), 0);
    repeat (5) @(posedge clk);
    #1 send(8'h42);
    push(0, 8'h05, 1'b0, 1'b0);
    send(8'hA5);
    send(8'h05);
    repeat (25) @(posedge clk);
    #1 check("final_q", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
